// File: rtl/log_quantizer_pipe.sv
// Two-stage log2 quantizer: leading-one exponent plus FRAC_W mantissa bits, valid/ready handshake.
// Define LOG_QUANT_ROUND_EN to round the mantissa half-up; otherwise it is truncated.
module log_quantizer_pipe #(
    parameter int DATA_W   = 10,
    parameter int FRAC_W   = 2,
    parameter int EXP_W    = $clog2(DATA_W),
    parameter int MAX_EXP  = DATA_W - 1,
    parameter int ZERO_EXP = 1,
    parameter int USER_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_sat,
    output logic [USER_W-1:0] out_user
);

    localparam logic [EXP_W:0] MAX_EXP_X = (EXP_W + 1)'(MAX_EXP);

    // Ascending scan where the last hit wins gives MSB priority.
    function automatic logic [EXP_W-1:0] lead_one(input logic [DATA_W-1:0] d);
        logic [EXP_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DATA_W; i++)
            if (d[i]) idx = EXP_W'(i);
        return idx;
    endfunction

`ifdef LOG_QUANT_ROUND_EN
    // m holds FRAC_W mantissa bits followed by the round bit; returns {exp_ext, frac}.
    function automatic logic [EXP_W+FRAC_W:0] round_half_up(input logic [EXP_W-1:0] e,
                                                            input logic [FRAC_W:0]  m);
        logic [FRAC_W:0] sum;
        logic [EXP_W:0]  e_inc;
        sum   = {1'b0, m[FRAC_W:1]} + {{FRAC_W{1'b0}}, m[0]};
        e_inc = {1'b0, e} + (EXP_W + 1)'(1);
        if (sum[FRAC_W])
            return {e_inc, {FRAC_W{1'b0}}};
        return {1'b0, e, sum[FRAC_W-1:0]};
    endfunction
`endif

    // Returns {exp, frac, zero, sat}.
    function automatic logic [EXP_W+FRAC_W+1:0] saturate(input logic [EXP_W:0]  e,
                                                         input logic [FRAC_W-1:0] f,
                                                         input logic              z);
        if (z)
            return {EXP_W'(ZERO_EXP), {FRAC_W{1'b0}}, 1'b1, 1'b0};
        if (e > MAX_EXP_X)
            return {EXP_W'(MAX_EXP), {FRAC_W{1'b1}}, 1'b0, 1'b1};
        return {e[EXP_W-1:0], f, 1'b0, 1'b0};
    endfunction

    logic              vld_p1, vld_p2;
    logic [DATA_W-1:0] data_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic              zero_p1;
    logic [USER_W-1:0] user_p1;

    logic [EXP_W-1:0]  exp_p2;
    logic [FRAC_W-1:0] frac_p2;
    logic              zero_p2, sat_p2;
    logic [USER_W-1:0] user_p2;

    logic s2_load;
    logic [EXP_W:0]    exp_rnd;
    logic [FRAC_W-1:0] frac_rnd;
    logic [EXP_W+FRAC_W+1:0] result;

    assign s2_load  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_load;

    // ---- stage 1: leading-one detect ----
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_p1 <= in_data;
            exp_p1  <= lead_one(in_data);
            zero_p1 <= (in_data == '0);
            user_p1 <= in_user;
        end
    end

    // Bits just below the leading one, zero-filled past bit 0.
`ifdef LOG_QUANT_ROUND_EN
    assign {exp_rnd, frac_rnd} =
        round_half_up(exp_p1, (FRAC_W + 1)'({data_p1, {(FRAC_W + 1){1'b0}}} >> exp_p1));
`else
    assign exp_rnd  = {1'b0, exp_p1};
    assign frac_rnd = FRAC_W'({data_p1, {FRAC_W{1'b0}}} >> exp_p1);
`endif

    assign result = saturate(exp_rnd, frac_rnd, zero_p1);

    // ---- stage 2: mantissa, clamp, output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            exp_p2  <= '0;
            frac_p2 <= '0;
            zero_p2 <= 1'b0;
            sat_p2  <= 1'b0;
            user_p2 <= '0;
        end else begin
            if (in_ready)
                vld_p1 <= in_valid;
            if (s2_load) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    {exp_p2, frac_p2, zero_p2, sat_p2} <= result;
                    user_p2 <= user_p1;
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_exp   = exp_p2;
    assign out_frac  = frac_p2;
    assign out_zero  = zero_p2;
    assign out_sat   = sat_p2;
    assign out_user  = user_p2;

endmodule
